// File: rtl/axis_matvec_coproc.sv
// rtl/axis_matvec_coproc.sv - AXI4-Stream matrix-vector coprocessor, RES = (A*B) >> SHIFT.
// Optional saturation of out-of-range results is enabled by defining MATVEC_SAT_EN.
module axis_matvec_coproc #(
  parameter int ROWS  = 64,
  parameter int COLS  = 8,
  parameter int WIDTH = 8,
  parameter int SHIFT = 8
) (
  input  logic        ACLK,
  input  logic        ARESET,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TVALID,
  output logic        M_AXIS_TVALID,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int IW = RW + CW;
  localparam int AW = 2 * WIDTH + CW;
  localparam logic [IW-1:0] A_LAST   = IW'(ROWS * COLS - 1);
  localparam logic [IW-1:0] B_LAST   = IW'(COLS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {RECV_A, RECV_B, COMPUTE, SEND} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     in_cnt_q, in_cnt_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic              s_tready_q, s_tready_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic              m_tlast_q, m_tlast_d;
  logic [WIDTH-1:0]  m_tdata_q, m_tdata_d;

  logic [WIDTH-1:0]  a_mem [ROWS*COLS];
  logic [WIDTH-1:0]  b_mem [COLS];
  logic [WIDTH-1:0]  res_mem [ROWS];

  logic              s_fire, m_fire, a_we, b_we, res_we;
  logic [2*WIDTH-1:0] prod;
  logic [AW-1:0]     acc_sum, acc_shift;
  logic [WIDTH-1:0]  res_val;
  logic              unused_bits;

  assign unused_bits   = ^{S_AXIS_TLAST, S_AXIS_TDATA[31:WIDTH]};
  assign s_fire        = S_AXIS_TVALID && s_tready_q;
  assign m_fire        = m_tvalid_q && M_AXIS_TREADY;
  assign S_AXIS_TREADY = s_tready_q;
  assign M_AXIS_TVALID = m_tvalid_q;
  assign M_AXIS_TLAST  = m_tlast_q;
  assign M_AXIS_TDATA  = {{(32-WIDTH){1'b0}}, m_tdata_q};

  // COLS is a power of two, so {row, col} is exactly the row-major index i*COLS+j.
  assign prod      = (2*WIDTH)'(a_mem[{row_q, col_q}]) * (2*WIDTH)'(b_mem[col_q]);
  assign acc_sum   = ((col_q == '0) ? '0 : acc_q) + AW'(prod);
  assign acc_shift = acc_sum >> SHIFT;
`ifdef MATVEC_SAT_EN
  assign res_val   = (|(acc_shift >> WIDTH)) ? {WIDTH{1'b1}} : acc_shift[WIDTH-1:0];
`else
  assign res_val   = acc_shift[WIDTH-1:0];
`endif

  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    acc_d      = acc_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tdata_d  = m_tdata_q;
    a_we       = 1'b0;
    b_we       = 1'b0;
    res_we     = 1'b0;
    case (state_q)
      RECV_A: if (s_fire) begin
        a_we = 1'b1;
        if (in_cnt_q == A_LAST) begin
          in_cnt_d = '0;
          state_d  = RECV_B;
        end else begin
          in_cnt_d = in_cnt_q + 1'b1;
        end
      end
      RECV_B: if (s_fire) begin
        b_we = 1'b1;
        if (in_cnt_q == B_LAST) begin
          in_cnt_d = '0;
          row_d    = '0;
          col_d    = '0;
          state_d  = COMPUTE;
        end else begin
          in_cnt_d = in_cnt_q + 1'b1;
        end
      end
      COMPUTE: begin
        acc_d = acc_sum;
        col_d = col_q + 1'b1;
        if (col_q == COL_LAST) begin
          res_we = 1'b1;
          row_d  = row_q + 1'b1;
          if (row_q == ROW_LAST) begin
            // RES[0] was written long before, so it can preload the output register now.
            row_d      = '0;
            state_d    = SEND;
            m_tvalid_d = 1'b1;
            m_tlast_d  = 1'b0;
            m_tdata_d  = res_mem[RW'(0)];
          end
        end
      end
      SEND: if (m_fire) begin
        if (m_tlast_q) begin
          state_d    = RECV_A;
          m_tvalid_d = 1'b0;
          m_tlast_d  = 1'b0;
          m_tdata_d  = '0;
        end else begin
          row_d     = row_q + 1'b1;
          m_tdata_d = res_mem[row_q + 1'b1];
          m_tlast_d = ((row_q + 1'b1) == ROW_LAST);
        end
      end
      default: state_d = RECV_A;
    endcase
    s_tready_d = (state_d == RECV_A) || (state_d == RECV_B);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= RECV_A;
      in_cnt_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      acc_q      <= '0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      acc_q      <= acc_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tdata_q  <= m_tdata_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (a_we)   a_mem[in_cnt_q]          <= S_AXIS_TDATA[WIDTH-1:0];
    if (b_we)   b_mem[in_cnt_q[CW-1:0]]  <= S_AXIS_TDATA[WIDTH-1:0];
    if (res_we) res_mem[row_q]           <= res_val;
  end
endmodule
